// File: rtl/mst_fifo_pkg.sv
// Shared constants and helpers for the master FIFO traffic/error monitor.
package mst_fifo_pkg;

  localparam int MST_CH_NUM = 4;
  localparam int EV_CH_W    = 2;

  // rd_sel[2] picks TX vs RX bank, rd_sel[1:0] the channel
  localparam int         RD_SEL_TX_BIT = 2;
  localparam logic [2:0] RD_SEL_RX0    = 3'd0;
  localparam logic [2:0] RD_SEL_TX0    = 3'd4;

  typedef logic [MST_CH_NUM-1:0] ch_vec_t;

  function automatic ch_vec_t lowest_one(input ch_vec_t v);
    return v & (~v + ch_vec_t'(1));
  endfunction

  function automatic logic [EV_CH_W-1:0] ch_idx(input ch_vec_t onehot);
    logic [EV_CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MST_CH_NUM; i++) begin
      if (onehot[i]) idx = EV_CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mst_mon_evq.sv
// Small first-word-fall-through synchronous FIFO holding monitor events.
module mst_mon_evq #(
  parameter int DW = 18,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = cnt_q[AW];
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the same cycle, so push-on-full is legal alongside it
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/mst_fifo_mon.sv
// Per-channel RX/TX word counters, seq_err edge event queue and stretched error LEDs.
module mst_fifo_mon
  import mst_fifo_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int TS_W     = 16,
  parameter int EVQ_AW   = 3,
  parameter int LED_HOLD = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    mltcn,
  input  logic [MST_CH_NUM-1:0]   rx_vld,
  input  logic [MST_CH_NUM-1:0]   tx_ack,
  input  logic [MST_CH_NUM-1:0]   seq_err,
  input  logic [2:0]              rd_sel,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic [MST_CH_NUM-1:0]   err_led,
  input  logic                    evq_pop,
  output logic                    evq_vld,
  output logic [EV_CH_W+TS_W-1:0] evq_dat,
  output logic                    evq_ovf
);

  localparam int EV_W  = EV_CH_W + TS_W;
  localparam int LED_W = $clog2(LED_HOLD + 1);

  ch_vec_t ch_mask, rx_m, tx_m, seq_m, edge_v, push_oh;
  ch_vec_t seq_dly_q, seq_dly_d, pend_q, pend_d, err_led_q, err_led_d;

  logic [CNT_W-1:0] rx_cnt_q [MST_CH_NUM];
  logic [CNT_W-1:0] rx_cnt_d [MST_CH_NUM];
  logic [CNT_W-1:0] tx_cnt_q [MST_CH_NUM];
  logic [CNT_W-1:0] tx_cnt_d [MST_CH_NUM];
  logic [TS_W-1:0]  cap_ts_q [MST_CH_NUM];
  logic [TS_W-1:0]  cap_ts_d [MST_CH_NUM];
  logic [LED_W-1:0] led_cnt_q [MST_CH_NUM];
  logic [LED_W-1:0] led_cnt_d [MST_CH_NUM];

  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               evq_ovf_q, evq_ovf_d, ovf_set;
  logic               evq_full, evq_empty;
  logic [EV_CH_W-1:0] push_ch;
  logic [EV_W-1:0]    evq_din;

  // 245 mode only has lane 0; upper lanes must not leak into any state
  assign ch_mask = mltcn ? '1 : ch_vec_t'(1);
  assign rx_m    = rx_vld  & ch_mask;
  assign tx_m    = tx_ack  & ch_mask;
  assign seq_m   = seq_err & ch_mask;
  assign edge_v  = seq_m & ~seq_dly_q;

  assign seq_dly_d = seq_m;
  assign ts_d      = ts_q + 1'b1;
  assign rd_cnt_d  = rd_sel[RD_SEL_TX_BIT] ? tx_cnt_q[rd_sel[1:0]] : rx_cnt_q[rd_sel[1:0]];

  always_comb begin
    for (int i = 0; i < MST_CH_NUM; i++) begin
      rx_cnt_d[i] = rx_cnt_q[i];
      tx_cnt_d[i] = tx_cnt_q[i];
      if (clr) begin
        rx_cnt_d[i] = '0;
        tx_cnt_d[i] = '0;
      end else begin
        if (rx_m[i] && (rx_cnt_q[i] != '1)) rx_cnt_d[i] = rx_cnt_q[i] + 1'b1;
        if (tx_m[i] && (tx_cnt_q[i] != '1)) tx_cnt_d[i] = tx_cnt_q[i] + 1'b1;
      end
    end
  end

  // one push per cycle, lowest pending channel first; a pop makes room in a full queue
  assign push_oh = (!evq_full || evq_pop) ? lowest_one(pend_q) : '0;
  assign push_ch = ch_idx(push_oh);
  assign evq_din = {push_ch, cap_ts_q[push_ch]};

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    for (int i = 0; i < MST_CH_NUM; i++) begin
      cap_ts_d[i] = cap_ts_q[i];
      if (push_oh[i]) pend_d[i] = 1'b0;
      if (edge_v[i]) begin
        if (pend_q[i] && !push_oh[i]) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i]   = 1'b1;
          cap_ts_d[i] = ts_q;
        end
      end
    end
    if (clr) pend_d = '0;
    evq_ovf_d = clr ? 1'b0 : (evq_ovf_q | ovf_set);
  end

  always_comb begin
    for (int i = 0; i < MST_CH_NUM; i++) begin
      if (edge_v[i])                led_cnt_d[i] = LED_W'(LED_HOLD);
      else if (led_cnt_q[i] != '0)  led_cnt_d[i] = led_cnt_q[i] - 1'b1;
      else                          led_cnt_d[i] = '0;
      err_led_d[i] = (led_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MST_CH_NUM; i++) begin
        rx_cnt_q[i]  <= '0;
        tx_cnt_q[i]  <= '0;
        cap_ts_q[i]  <= '0;
        led_cnt_q[i] <= '0;
      end
      rd_cnt_q  <= '0;
      ts_q      <= '0;
      seq_dly_q <= '0;
      pend_q    <= '0;
      evq_ovf_q <= 1'b0;
      err_led_q <= '0;
    end else begin
      for (int i = 0; i < MST_CH_NUM; i++) begin
        rx_cnt_q[i]  <= rx_cnt_d[i];
        tx_cnt_q[i]  <= tx_cnt_d[i];
        cap_ts_q[i]  <= cap_ts_d[i];
        led_cnt_q[i] <= led_cnt_d[i];
      end
      rd_cnt_q  <= rd_cnt_d;
      ts_q      <= ts_d;
      seq_dly_q <= seq_dly_d;
      pend_q    <= pend_d;
      evq_ovf_q <= evq_ovf_d;
      err_led_q <= err_led_d;
    end
  end

  mst_mon_evq #(
    .DW (EV_W),
    .AW (EVQ_AW)
  ) u_evq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (|push_oh),
    .din   (evq_din),
    .pop   (evq_pop),
    .full  (evq_full),
    .empty (evq_empty),
    .dout  (evq_dat)
  );

  assign evq_vld = ~evq_empty;
  assign evq_ovf = evq_ovf_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_led = err_led_q;

endmodule
